// File: rtl/dlx_pkg.sv
// Shared phase encoding for the DLX phase sequencer.
package dlx_pkg;
  localparam int PHASE_W = 3;

  typedef enum logic [PHASE_W-1:0] {
    PH_IF    = 3'd0,
    PH_ID    = 3'd1,
    PH_EX    = 3'd2,
    PH_MEM   = 3'd3,
    PH_WB    = 3'd4,
    PH_HALT  = 3'd5,
    PH_FAULT = 3'd6
  } phase_t;
endpackage

// File: rtl/dlx_wait_timer.sv
// Stall timer for memory-wait phases; expired flags the last tolerated stall cycle.
module dlx_wait_timer #(
  parameter int MAX_WAIT = 255,
  parameter int WAIT_W   = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [WAIT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (en && !expired)   cnt <= cnt + WAIT_W'(1);
  end

  assign expired = (cnt == WAIT_W'(MAX_WAIT));
endmodule

// File: rtl/dlx_seq.sv
// Multi-cycle phase sequencer: IF/ID/EX/MEM/WB with memory waits, halt,
// timeout fault and saturating retire/stall counters.
module dlx_seq
  import dlx_pkg::*;
#(
  parameter int MAX_WAIT = 255,
  parameter int WAIT_W   = 8,
  parameter int CNT_W    = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_data_valid,
  input  logic               d_data_valid,
  input  logic               need_mem,
  input  logic               need_wb,
  input  logic               halt_req,
  output logic               IF,
  output logic               ID,
  output logic               EX,
  output logic               MEM,
  output logic               WB,
  output logic               busy,
  output logic               fault,
  output logic [PHASE_W-1:0] fault_phase,
  output logic [CNT_W-1:0]   instr_count,
  output logic [CNT_W-1:0]   stall_count
);
  phase_t state;
  logic   need_mem_q, need_wb_q, halt_q;
  logic   stall, retire, expired;

  assign stall  = (state == PH_IF  && !i_data_valid) ||
                  (state == PH_MEM && !d_data_valid);
  assign retire = (state == PH_EX  && !need_mem_q && !need_wb_q) ||
                  (state == PH_MEM && d_data_valid && !need_wb_q) ||
                  (state == PH_WB);

  // Any non-stall cycle clears the timer, so it is zero on every IF/MEM entry.
  dlx_wait_timer #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (!stall),
    .en      (stall),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= PH_IF;
      need_mem_q  <= 1'b0;
      need_wb_q   <= 1'b0;
      halt_q      <= 1'b0;
      fault       <= 1'b0;
      fault_phase <= '0;
      instr_count <= '0;
      stall_count <= '0;
    end else begin
      if (stall && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
      if (retire && instr_count != '1) instr_count <= instr_count + CNT_W'(1);
      if (halt_req && state != PH_FAULT && state != PH_HALT) halt_q <= 1'b1;

      if (retire) begin
        state <= halt_q ? PH_HALT : PH_IF;
      end else begin
        case (state)
          PH_IF:
            if (i_data_valid) state <= PH_ID;
            else if (expired) begin
              state       <= PH_FAULT;
              fault       <= 1'b1;
              fault_phase <= PH_IF;
            end
          PH_ID: begin
            need_mem_q <= need_mem;
            need_wb_q  <= need_wb;
            state      <= PH_EX;
          end
          PH_EX:
            state <= need_mem_q ? PH_MEM : PH_WB;
          PH_MEM:
            if (d_data_valid) state <= PH_WB;
            else if (expired) begin
              state       <= PH_FAULT;
              fault       <= 1'b1;
              fault_phase <= PH_MEM;
            end
          PH_HALT:
            if (!halt_req) begin
              state  <= PH_IF;
              halt_q <= 1'b0;
            end
          default: ;
        endcase
      end
    end
  end

  assign IF   = (state == PH_IF);
  assign ID   = (state == PH_ID);
  assign EX   = (state == PH_EX);
  assign MEM  = (state == PH_MEM);
  assign WB   = (state == PH_WB);
  assign busy = (state != PH_HALT) && (state != PH_FAULT);
endmodule

// File: doc/dlx_seq.md
# dlx_seq

Parametrised multi-cycle phase sequencer for the DLX core, replacing the fixed IF/ID/EX/MEM/WB ring. It waits on the instruction and data memory valid handshakes and skips MEM or WB per decoded instruction. It also halts at instruction boundaries, detects memory timeouts, and keeps retired-instruction and stall counters. It sits beside the decoder and drives the phase enables consumed by pc, decoder, ALU, regs and the memory write gate.

## Interface
- `MAX_WAIT`, 255: stalled cycles tolerated in IF or MEM before fault; legal 1..2^WAIT_W-1
- `WAIT_W`, 8: wait counter width
- `CNT_W`, 32: width of performance counters

- `clk`  in  1  system clock; one clock domain
- `reset_n`  in  1  asynchronous, active-low reset
- `i_data_valid`  in  1  instruction ROM read complete
- `d_data_valid`  in  1  data RAM access complete
- `need_mem`  in  1  decoded instruction uses MEM; sampled on the last ID cycle
- `need_wb`  in  1  decoded instruction writes a register; sampled on the last ID cycle
- `halt_req`  in  1  request a stop at the next instruction boundary
- `IF`, `ID`, `EX`, `MEM`, `WB`  out  1 each  one-hot phase enables; all 0 in HALT/FAULT
- `busy`  out  1  high in IF..WB
- `fault`  out  1  sticky timeout flag
- `fault_phase`  out  3  phase code of the timed-out phase
- `instr_count`  out  CNT_W  retired instructions, saturating
- `stall_count`  out  CNT_W  stalled cycles, saturating

## Operation
- States: IF, ID, EX, MEM, WB, HALT, FAULT. Reset: state IF, IF=1, busy=1, fault=0, fault_phase=0, all counters 0, halt latch 0.
- IF: holds while i_data_valid=0, then goes to ID on the cycle i_data_valid=1.
- ID: one cycle, then EX. Latches need_mem and need_wb.
- EX: one cycle. Next state is MEM if need_mem; else WB if need_wb; else retire.
- MEM: holds while d_data_valid=0. On valid, goes to WB if need_wb, else retires.
- WB: one cycle, then retire.
- Retire: instr_count+1. Next state is HALT if the halt latch is set, else IF.
- Halt latch: set by halt_req=1 in any cycle; cleared on HALT exit. HALT goes to IF on the first cycle with halt_req=0.
- Wait counter:
  - cleared on entry to IF or MEM;
  - +1 on every cycle the phase stalls; stall_count also +1 on every such cycle;
  - if valid=0 while the counter equals MAX_WAIT, the next state is FAULT.
- Valid asserted on the MAX_WAIT cycle: valid wins, no fault.
- FAULT: fault=1. fault_phase holds the phase code (IF=0, MEM=3). Valids and halt_req are ignored. Only reset exits FAULT.
- Counters saturate at all-ones and never wrap.

## Timing
- Every output is a Moore decode of registered state and counters; there is no combinational input-to-output path.
- Minimum instruction length with zero-wait memory: 3 cycles (IF, ID, EX), 4 with WB, 5 with MEM and WB.
- Each stalled cycle adds 1 cycle to IF or MEM. A phase faults after MAX_WAIT+1 cycles with valid low.
- Counter updates become visible on the cycle after the triggering edge.
- Reset assertion mid-phase takes effect immediately: outputs return to their reset values asynchronously, with no partial retire.

## Structure
- Shared package `dlx_pkg`:
  - `phase_t` enum with codes IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5, FAULT=6;
  - `PHASE_W`=3.
- Sub-module `dlx_wait_timer`: clear/enable inputs, WAIT_W counter, `expired` output asserted when count equals MAX_WAIT.
- `dlx_seq` holds the FSM, need_* latches, halt latch, fault registers and saturating counters.

## Test plan
- Reset; i_data_valid=1 constantly, need_mem=0, need_wb=1 -> phase sequence IF,ID,EX,WB repeating every 4 cycles; after 3 instructions instr_count=3, stall_count=0.
- Load: need_mem=1, need_wb=1, d_data_valid asserted 3 cycles after MEM entry -> MEM lasts 4 cycles, then WB, then retire; stall_count=3.
- Store and branch: need_mem=1, need_wb=0 gives EX,MEM,IF with no WB pulse. need_mem=0, need_wb=0 gives EX,IF.
- Timeout with MAX_WAIT=4, i_data_valid=0 -> IF held 5 cycles, then fault=1, fault_phase=0, all phase outputs 0, busy=0. A later i_data_valid=1 is ignored. A variant asserting valid on the 5th IF cycle goes to ID with no fault.
- 1-cycle halt_req pulse during EX of an ALU op -> WB completes, instr_count increments, HALT for 1 cycle, then IF. With halt_req held high, HALT persists until release.
- reset_n low mid-MEM with counters nonzero -> IF=1, busy=1, instr_count=0, stall_count=0, fault=0 immediately and without waiting for clk.
